mult_div_unit: RTL and testbench

- Iterative multiply/divide unit for the MIPS datapath. Executes MULT, MULTU, DIV and DIVU into dedicated HI/LO registers.
- Also services MTHI/MTLO writes.
- HI and LO outputs feed the register-file writeback multiplexer directly; that path implements MFHI/MFLO.
- The control unit stalls the PC while busy is high.

---
 rtl/mult_div_unit.sv | 157 +++++++++++++++
 tb/tb_mult_div_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO result registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring shift-subtract on magnitudes.
// Signs are fixed up in a final cycle. MTHI/MTLO writes are accepted only while idle.
module mult_div_unit #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [1:0]   op,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic         hi_wr,
   input  logic         lo_wr,
   input  logic [W-1:0] wr_data,
   output logic [W-1:0] HI,
   output logic [W-1:0] LO,
   output logic         busy,
   output logic         done
);

   localparam int unsigned CW = $clog2(W);

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

   state_t           state, state_n;
   logic             is_div, is_div_n;
   logic             sgn_q, sgn_q_n;
   logic             sgn_r, sgn_r_n;
   logic             bzero, bzero_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [2*W-1:0]   acc, acc_n;     // mult: {partial product, multiplier}; div: low half holds quotient
   logic [W-1:0]     rem, rem_n;     // restored partial remainder (always < divisor)
   logic [W-1:0]     opnd, opnd_n;   // multiplicand or divisor magnitude
   logic [W-1:0]     hi_n, lo_n;
   logic             busy_n, done_n;

   logic             op_signed;
   logic [W-1:0]     mag_a, mag_b;
   logic [W:0]       mul_sum;
   logic [W:0]       div_shift;
   logic             div_ge;
   logic [W-1:0]     div_diff;
   logic [2*W-1:0]   prod_fix;
   logic [W-1:0]     quo_fix, rem_fix;

   // Operand magnitudes; the most-negative value maps to its unsigned magnitude.
   assign op_signed = ~op[0];
   assign mag_a     = (op_signed && A[W-1]) ? (~A + W'(1)) : A;
   assign mag_b     = (op_signed && B[W-1]) ? (~B + W'(1)) : B;

   // One shift-add step: conditionally add multiplicand into the upper half, keeping the carry.
   assign mul_sum   = acc[0] ? ({1'b0, acc[2*W-1:W]} + {1'b0, opnd}) : {1'b0, acc[2*W-1:W]};

   // One restoring step: W+1-bit shifted partial remainder compared against the divisor.
   assign div_shift = {rem, acc[W-1]};
   assign div_ge    = (div_shift >= {1'b0, opnd});
   assign div_diff  = div_shift[W-1:0] - opnd;

   // Final sign correction; a zero divisor forces an all-ones quotient.
   assign prod_fix  = sgn_q ? (~acc + (2*W)'(1)) : acc;
   assign quo_fix   = bzero ? '1 : (sgn_q ? (~acc[W-1:0] + W'(1)) : acc[W-1:0]);
   assign rem_fix   = sgn_r ? (~rem + W'(1)) : rem;

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         is_div <= 1'b0;
         sgn_q  <= 1'b0;
         sgn_r  <= 1'b0;
         bzero  <= 1'b0;
         cnt    <= '0;
         acc    <= '0;
         rem    <= '0;
         opnd   <= '0;
         HI     <= '0;
         LO     <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_n;
         is_div <= is_div_n;
         sgn_q  <= sgn_q_n;
         sgn_r  <= sgn_r_n;
         bzero  <= bzero_n;
         cnt    <= cnt_n;
         acc    <= acc_n;
         rem    <= rem_n;
         opnd   <= opnd_n;
         HI     <= hi_n;
         LO     <= lo_n;
         busy   <= busy_n;
         done   <= done_n;
      end
   end

   // Next-state and next-register logic.
   always_comb begin
      state_n  = state;
      is_div_n = is_div;
      sgn_q_n  = sgn_q;
      sgn_r_n  = sgn_r;
      bzero_n  = bzero;
      cnt_n    = cnt;
      acc_n    = acc;
      rem_n    = rem;
      opnd_n   = opnd;
      hi_n     = HI;
      lo_n     = LO;
      busy_n   = busy;
      done_n   = 1'b0;

      case (state)
         IDLE: begin
            if (hi_wr) hi_n = wr_data;
            if (lo_wr) lo_n = wr_data;
            if (start) begin
               is_div_n = op[1];
               sgn_q_n  = op_signed & (A[W-1] ^ B[W-1]);
               sgn_r_n  = op_signed & A[W-1];
               bzero_n  = (B == '0);
               opnd_n   = op[1] ? mag_b : mag_a;
               acc_n    = {{W{1'b0}}, (op[1] ? mag_a : mag_b)};
               rem_n    = '0;
               cnt_n    = CW'(W - 1);
               busy_n   = 1'b1;
               state_n  = CALC;
            end
         end
         CALC: begin
            if (is_div) begin
               acc_n = {acc[2*W-1:W], acc[W-2:0], div_ge};
               rem_n = div_ge ? div_diff : div_shift[W-1:0];
            end else begin
               acc_n = {mul_sum, acc[W-1:1]};
            end
            cnt_n = cnt - CW'(1);
            if (cnt == '0) state_n = FIN;
         end
         FIN: begin
            if (is_div) begin
               hi_n = rem_fix;
               lo_n = quo_fix;
            end else begin
               hi_n = prod_fix[2*W-1:W];
               lo_n = prod_fix[W-1:0];
            end
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed vectors, expected HI/LO queued at launch.
module tb_mult_div_unit;

   localparam int unsigned W = 32;

   logic         clk;
   logic         reset;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] A, B;
   logic         hi_wr, lo_wr;
   logic [W-1:0] wr_data;
   logic [W-1:0] HI, LO;
   logic         busy, done;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      int           cyc;
      string        nm;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;

   mult_div_unit #(.W(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
      .hi_wr(hi_wr), .lo_wr(lo_wr), .wr_data(wr_data),
      .HI(HI), .LO(LO), .busy(busy), .done(done)
   );

   // Clock and cycle counter.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string nm, input logic [W-1:0] act, input logic [W-1:0] ev);
      n_cmp++;
      if (act !== ev) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, ev);
      end
   endfunction

   // Monitor: every done pulse retires one scoreboard entry.
   always @(negedge clk) begin
      if (done && !reset) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_done: got done with HI=%h LO=%h, expected no result", HI, LO);
         end else begin
            mon_e = sb.pop_front();
            check({mon_e.nm, "_hi"}, HI, mon_e.hi);
            check({mon_e.nm, "_lo"}, LO, mon_e.lo);
            check({mon_e.nm, "_latency"}, W'(cyc), W'(mon_e.cyc));
            check({mon_e.nm, "_busy_at_done"}, W'(busy), W'(0));
         end
      end
   end

   // Launch one operation, optionally disturbing it mid-flight, and wait for completion.
   task automatic run(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] eh, input logic [W-1:0] el, input string nm,
                      input bit disturb, input bit mt);
      exp_t e;
      int   bc;
      bit   seen;
      @(negedge clk);
      start = 1'b1; op = o; A = a; B = b;
      if (mt) begin hi_wr = 1'b1; wr_data = 32'h0000_5555; end
      e.hi = eh; e.lo = el; e.cyc = cyc + int'(W) + 2; e.nm = nm;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0; hi_wr = 1'b0; op = 2'b00; A = '0; B = '0;
      if (mt) check({nm, "_mt_with_start"}, HI, 32'h0000_5555);
      bc   = 0;
      seen = 1'b0;
      for (int i = 0; i < 3 * int'(W) && !seen; i++) begin
         if (done) begin
            seen = 1'b1;
         end else begin
            if (busy) bc++;
            if (disturb && bc == 5) begin
               start = 1'b1; op = 2'b01; A = 32'd9; B = 32'd9;
               hi_wr = 1'b1; wr_data = 32'h0000_DEAD;
            end else begin
               start = 1'b0; hi_wr = 1'b0;
            end
            @(negedge clk);
         end
      end
      start = 1'b0; hi_wr = 1'b0;
      check({nm, "_done_seen"}, W'(seen), W'(1));
      check({nm, "_busy_cycles"}, W'(bc), W + 1);
      @(negedge clk);
      check({nm, "_done_pulse_len"}, W'(done), W'(0));
   endtask

   // Watchdog.
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Stimulus.
   initial begin
      reset = 1'b1; start = 1'b0; op = 2'b00; A = '0; B = '0;
      hi_wr = 1'b0; lo_wr = 1'b0; wr_data = '0;
      repeat (2) @(negedge clk);
      check("reset_hi",   HI, '0);
      check("reset_lo",   LO, '0);
      check("reset_busy", W'(busy), W'(0));
      check("reset_done", W'(done), W'(0));
      reset = 1'b0;

      run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max",    0, 0);
      run(2'b00, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg_a",   0, 0);
      run(2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg_a",    0, 0);
      run(2'b00, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2, "mult_neg_b",   0, 0);
      run(2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_neg_b",    0, 0);
      run(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minmin",  0, 0);
      run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_overflow", 0, 0);
      run(2'b11, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, "divu_zero",    0, 0);
      run(2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_zero_neg", 0, 0);
      run(2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        "divu_disturb", 1, 0);

      // MTHI and MTLO together, then MTLO alone.
      @(negedge clk);
      hi_wr = 1'b1; lo_wr = 1'b1; wr_data = 32'hA5A5_A5A5;
      @(negedge clk);
      hi_wr = 1'b0; lo_wr = 1'b0;
      check("mt_both_hi",   HI, 32'hA5A5_A5A5);
      check("mt_both_lo",   LO, 32'hA5A5_A5A5);
      check("mt_both_busy", W'(busy), W'(0));
      check("mt_both_done", W'(done), W'(0));
      lo_wr = 1'b1; wr_data = 32'h1111_1111;
      @(negedge clk);
      lo_wr = 1'b0;
      check("mtlo_only_lo", LO, 32'h1111_1111);
      check("mtlo_only_hi", HI, 32'hA5A5_A5A5);

      // Reset in the middle of a multiply discards the result immediately.
      @(negedge clk);
      start = 1'b1; op = 2'b01; A = 32'h0001_2345; B = 32'h0006_7890;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      check("pre_reset_busy", W'(busy), W'(1));
      reset = 1'b1;
      #1;
      check("midreset_hi",   HI, '0);
      check("midreset_lo",   LO, '0);
      check("midreset_busy", W'(busy), W'(0));
      check("midreset_done", W'(done), W'(0));
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("post_reset_busy", W'(busy), W'(0));
      check("post_reset_hi",   HI, '0);

      run(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, "multu_after_reset", 0, 1);

      repeat (2) @(negedge clk);
      check("scoreboard_empty", W'(sb.size()), W'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
